pc_fetch_ctrl: RTL and testbench

- Sequencer that owns the program counter's write port (wrEnable/addrIn) and the instruction-memory fetch handshake.
- Decides each cycle whether the PC holds, increments, or is redirected, and delivers fetched instructions to decode.
- Arbitrates redirect sources (exception > branch, plus optional interrupt).
- Buffers a redirect that arrives while a fetch is outstanding.

---
 rtl/pc_fetch_ctrl_pkg.sv | 18 +
 rtl/pc_fetch_ctrl_redirect_arb.sv | 70 +++++++
 rtl/pc_fetch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// rtl/pc_fetch_ctrl_pkg.sv - shared fetch types, address width and PC vectors
package pc_fetch_ctrl_pkg;

  // Width of every instruction-address path (PC, fetch, decode, redirects)
  localparam int unsigned INSN_ADDR_WIDTH = 32;

  localparam logic [31:0] INSN_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] INSN_PC_INC       = 32'h0000_0004;
  localparam logic [31:0] PC_EXC_VECTOR     = 32'h0000_0100;
  localparam logic [31:0] PC_IRQ_VECTOR     = 32'h0000_0200;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_redirect_arb.sv
// rtl/pc_fetch_ctrl_redirect_arb.sv - pc_redirect_arb: redirect winner across live inputs and pending state (PC_FETCH_IRQ_EN adds irq)
module pc_redirect_arb
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = INSN_ADDR_WIDTH,
`ifdef PC_FETCH_IRQ_EN
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR = ADDR_WIDTH'(PC_IRQ_VECTOR),
`endif
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = ADDR_WIDTH'(PC_EXC_VECTOR)
) (
  input  logic                  exc_req,
  input  logic                  br_taken,
  input  logic [ADDR_WIDTH-1:0] br_target,
`ifdef PC_FETCH_IRQ_EN
  input  logic                  irq_req,
  output logic                  irq_taken,
`endif
  input  logic                  pend_valid,
  input  logic                  pend_exc,
  input  logic [ADDR_WIDTH-1:0] pend_addr,
  output logic                  win_valid,
  output logic [ADDR_WIDTH-1:0] win_addr,
  output logic                  win_is_exc
);

  logic                  new_valid;
  logic                  new_exc;
  logic                  new_ok;
  logic [ADDR_WIDTH-1:0] new_addr;

`ifdef PC_FETCH_IRQ_EN
  logic irq_ok;
  logic irq_sel;

  // An interrupt already heading to IRQ_VECTOR must not be re-taken (would clobber epc)
  assign irq_ok = irq_req && !(pend_valid && !pend_exc && (pend_addr == IRQ_VECTOR));
`endif

  // Priority pick among live sources, then merge with pending: only an exception displaces a pending exception
  always_comb begin
    new_valid = 1'b0;
    new_exc   = 1'b0;
    new_addr  = br_target;
`ifdef PC_FETCH_IRQ_EN
    irq_sel   = 1'b0;
`endif
    if (exc_req) begin
      new_valid = 1'b1;
      new_exc   = 1'b1;
      new_addr  = EXC_VECTOR;
    end else if (br_taken) begin
      new_valid = 1'b1;
      new_addr  = br_target;
`ifdef PC_FETCH_IRQ_EN
    end else if (irq_ok) begin
      new_valid = 1'b1;
      new_addr  = IRQ_VECTOR;
      irq_sel   = 1'b1;
`endif
    end
    new_ok     = new_valid && (!pend_valid || !pend_exc || new_exc);
    win_valid  = new_ok || pend_valid;
    win_addr   = new_ok ? new_addr : pend_addr;
    win_is_exc = new_ok ? new_exc : pend_exc;
`ifdef PC_FETCH_IRQ_EN
    irq_taken  = new_ok && irq_sel;
`endif
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC write-port sequencer and imem fetch handshake; PC_FETCH_IRQ_EN enables irqReq/epc
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = INSN_ADDR_WIDTH,
`ifdef PC_FETCH_IRQ_EN
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR = ADDR_WIDTH'(PC_IRQ_VECTOR),
`endif
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = ADDR_WIDTH'(PC_EXC_VECTOR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pcCur,
  output logic                  pcWrEnable,
  output logic [ADDR_WIDTH-1:0] pcWrAddr,
  output logic                  imemReq,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  input  logic                  imemAck,
  output logic                  insnValid,
  output logic [ADDR_WIDTH-1:0] insnAddr,
  input  logic                  insnReady,
  input  logic                  brTaken,
  input  logic [ADDR_WIDTH-1:0] brTarget,
`ifdef PC_FETCH_IRQ_EN
  input  logic                  irqReq,
  output logic [ADDR_WIDTH-1:0] epc,
`endif
  input  logic                  excReq
);

  fetch_state_e          state_q, state_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  pend_exc_q, pend_exc_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;

  logic                  win_valid;
  logic                  win_is_exc;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  resp_cycle;

`ifdef PC_FETCH_IRQ_EN
  logic                  irq_taken;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;

  assign epc = epc_q;
`endif

  pc_redirect_arb #(
    .ADDR_WIDTH (ADDR_WIDTH),
`ifdef PC_FETCH_IRQ_EN
    .IRQ_VECTOR (IRQ_VECTOR),
`endif
    .EXC_VECTOR (EXC_VECTOR)
  ) u_arb (
    .exc_req    (excReq),
    .br_taken   (brTaken),
    .br_target  (brTarget),
`ifdef PC_FETCH_IRQ_EN
    .irq_req    (irqReq),
    .irq_taken  (irq_taken),
`endif
    .pend_valid (pend_valid_q),
    .pend_exc   (pend_exc_q),
    .pend_addr  (pend_addr_q),
    .win_valid  (win_valid),
    .win_addr   (win_addr),
    .win_is_exc (win_is_exc)
  );

  // A response only counts once a request has been issued; a stale ack in IDLE is dropped
  assign resp_cycle = imemAck && ((state_q == FETCH_REQ) || (state_q == FETCH_WAIT));

  // State and pending-redirect registers; reset drops any pending redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH_IDLE;
      pend_valid_q <= 1'b0;
      pend_exc_q   <= 1'b0;
      pend_addr_q  <= '0;
`ifdef PC_FETCH_IRQ_EN
      epc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_exc_q   <= pend_exc_d;
      pend_addr_q  <= pend_addr_d;
`ifdef PC_FETCH_IRQ_EN
      epc_q        <= epc_d;
`endif
    end
  end

  // Next state: a response always returns to REQ; a redirect without a response is parked as pending
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_exc_d   = pend_exc_q;
    pend_addr_d  = pend_addr_q;
    case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_REQ;
      end
      FETCH_REQ, FETCH_WAIT: begin
        if (imemAck) begin
          state_d      = FETCH_REQ;
          pend_valid_d = 1'b0;
          pend_exc_d   = 1'b0;
        end else begin
          // In REQ the redirect is also written to the PC now, but the request in flight
          // must still be drained, so it is remembered to discard that response.
          state_d      = FETCH_WAIT;
          pend_valid_d = win_valid;
          pend_exc_d   = win_is_exc;
          pend_addr_d  = win_valid ? win_addr : pend_addr_q;
        end
      end
      default: begin
        state_d      = FETCH_IDLE;
        pend_valid_d = 1'b0;
        pend_exc_d   = 1'b0;
      end
    endcase
  end

`ifdef PC_FETCH_IRQ_EN
  // Return PC is the next instruction that has not been delivered yet
  always_comb begin
    epc_d = epc_q;
    if (irq_taken) begin
      epc_d = pend_valid_q ? pend_addr_q : pcCur;
    end
  end
`endif

  // Outputs: hold by default, deliver or discard on a response, apply redirects immediately outside WAIT
  always_comb begin
    pcWrEnable = 1'b1;
    pcWrAddr   = pcCur;
    imemReq    = 1'b0;
    imemAddr   = pcCur;
    insnValid  = 1'b0;
    insnAddr   = pcCur;
    if (rst) begin
      imemReq = (state_q == FETCH_REQ);
      if (resp_cycle) begin
        if (win_valid) begin
          pcWrAddr = win_addr;
        end else begin
          insnValid = 1'b1;
          if (insnReady) begin
            pcWrEnable = 1'b0;
          end
        end
      end else if ((state_q != FETCH_WAIT) && win_valid) begin
        pcWrAddr = win_addr;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed bench for pc_fetch_ctrl with a behavioural PC register
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pcCur;
  logic        pcWrEnable;
  logic [31:0] pcWrAddr;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic        insnValid;
  logic [31:0] insnAddr;
  logic        insnReady;
  logic        brTaken;
  logic [31:0] brTarget;
  logic        excReq;
`ifdef PC_FETCH_IRQ_EN
  logic        irqReq;
  logic [31:0] epc;
`endif

  logic        zl;
  logic        ack_drv;
  int          total;
  int          bad;

  pc_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pcCur      (pcCur),
    .pcWrEnable (pcWrEnable),
    .pcWrAddr   (pcWrAddr),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemAck    (imemAck),
    .insnValid  (insnValid),
    .insnAddr   (insnAddr),
    .insnReady  (insnReady),
    .brTaken    (brTaken),
    .brTarget   (brTarget),
`ifdef PC_FETCH_IRQ_EN
    .irqReq     (irqReq),
    .epc        (epc),
`endif
    .excReq     (excReq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // zero-latency memory answers the request in the same cycle; otherwise ack is scripted
  assign imemAck = zl ? imemReq : ack_drv;

  // PC register: increments when wrEnable is low, otherwise loads addrIn
  always @(posedge clk or negedge rst) begin
    if (!rst)             pcCur <= INSN_RESET_VECTOR;
    else if (!pcWrEnable) pcCur <= pcCur + INSN_PC_INC;
    else                  pcCur <= pcWrAddr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; zl = 1'b0; ack_drv = 1'b0; insnReady = 1'b1;
    brTaken = 1'b0; brTarget = 32'h0; excReq = 1'b0;
`ifdef PC_FETCH_IRQ_EN
    irqReq = 1'b0;
`endif
    repeat (2) @(negedge clk);
    brTaken = 1'b1; brTarget = 32'h80; #1;
    chk("rst_req",   32'(imemReq),    32'd0);
    chk("rst_valid", 32'(insnValid),  32'd0);
    chk("rst_we",    32'(pcWrEnable), 32'd1);
    chk("rst_waddr", pcWrAddr,        32'h0);

    @(negedge clk); brTaken = 1'b0; rst = 1'b1; zl = 1'b1; #1;
    chk("idle_req",   32'(imemReq),    32'd0);
    chk("idle_we",    32'(pcWrEnable), 32'd1);
    chk("idle_valid", 32'(insnValid),  32'd0);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("zl_valid", 32'(insnValid),  32'd1);
      chk("zl_addr",  insnAddr,        32'(i * 4));
      chk("zl_we",    32'(pcWrEnable), 32'd0);
    end

    for (int i = 0; i < 2; i++) begin
      @(negedge clk); insnReady = 1'b0; #1;
      chk("replay_valid", 32'(insnValid),  32'd1);
      chk("replay_addr",  insnAddr,        32'h10);
      chk("replay_we",    32'(pcWrEnable), 32'd1);
      chk("replay_waddr", pcWrAddr,        32'h10);
    end
    @(negedge clk); insnReady = 1'b1; #1;
    chk("accept_addr", insnAddr,        32'h10);
    chk("accept_we",   32'(pcWrEnable), 32'd0);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk); zl = 1'b0; ack_drv = 1'b0; #1;
      chk("lat_req",   32'(imemReq),   32'd1);
      chk("lat_iaddr", imemAddr,       32'(32'h14 + i * 4));
      chk("lat_valid", 32'(insnValid), 32'd0);
      @(negedge clk); #1;
      chk("wait_req",   32'(imemReq),    32'd0);
      chk("wait_we",    32'(pcWrEnable), 32'd1);
      chk("wait_waddr", pcWrAddr,        32'(32'h14 + i * 4));
      @(negedge clk); ack_drv = 1'b1; #1;
      chk("lat_dvalid", 32'(insnValid),  32'd1);
      chk("lat_daddr",  insnAddr,        32'(32'h14 + i * 4));
      chk("lat_dwe",    32'(pcWrEnable), 32'd0);
    end

    @(negedge clk); ack_drv = 1'b0; #1;
    chk("br_req", 32'(imemReq), 32'd1);
    @(negedge clk); brTaken = 1'b1; brTarget = 32'h80; #1;
    chk("br_wait_waddr", pcWrAddr,       32'h1C);
    chk("br_wait_valid", 32'(insnValid), 32'd0);
    @(negedge clk); brTaken = 1'b0; #1;
    chk("br_wait2_waddr", pcWrAddr, 32'h1C);
    @(negedge clk); ack_drv = 1'b1; #1;
    chk("br_discard", 32'(insnValid),  32'd0);
    chk("br_we",      32'(pcWrEnable), 32'd1);
    chk("br_waddr",   pcWrAddr,        32'h80);
    @(negedge clk); #1;
    chk("br_next_valid", 32'(insnValid), 32'd1);
    chk("br_next_addr",  insnAddr,       32'h80);

    @(negedge clk); ack_drv = 1'b0; excReq = 1'b1; brTaken = 1'b1; brTarget = 32'h300; #1;
    chk("exc_req",   32'(imemReq),   32'd1);
    chk("exc_waddr", pcWrAddr,       32'h100);
    chk("exc_valid", 32'(insnValid), 32'd0);
    @(negedge clk); excReq = 1'b0; #1;
    chk("exc_hold_waddr", pcWrAddr, 32'h100);
    @(negedge clk); brTaken = 1'b0; ack_drv = 1'b1; #1;
    chk("exc_discard", 32'(insnValid), 32'd0);
    chk("exc_keep",    pcWrAddr,       32'h100);
    @(negedge clk); #1;
    chk("exc_next_valid", 32'(insnValid), 32'd1);
    chk("exc_next_addr",  insnAddr,       32'h100);

`ifdef PC_FETCH_IRQ_EN
    @(negedge clk); brTaken = 1'b1; brTarget = 32'h40; #1;
    chk("irq_pre_waddr", pcWrAddr, 32'h40);
    @(negedge clk); brTaken = 1'b0; irqReq = 1'b1; #1;
    chk("irq_waddr", pcWrAddr,       32'h200);
    chk("irq_valid", 32'(insnValid), 32'd0);
    chk("irq_epc0",  epc,            32'h0);
    @(negedge clk); irqReq = 1'b0; ack_drv = 1'b0; #1;
    chk("irq_epc",   epc,      32'h40);
    chk("irq_iaddr", imemAddr, 32'h200);
`else
    @(negedge clk); ack_drv = 1'b0; #1;
    chk("pre_wait_req", 32'(imemReq), 32'd1);
`endif

    @(negedge clk); brTaken = 1'b1; brTarget = 32'h500; #1;
    chk("mid_wait_req", 32'(imemReq), 32'd0);
    @(negedge clk); brTaken = 1'b0; rst = 1'b0; #1;
    chk("mrst_req",   32'(imemReq),    32'd0);
    chk("mrst_we",    32'(pcWrEnable), 32'd1);
    chk("mrst_waddr", pcWrAddr,        32'h0);
`ifdef PC_FETCH_IRQ_EN
    chk("mrst_epc",   epc,             32'h0);
`endif
    @(negedge clk); rst = 1'b1; ack_drv = 1'b1; #1;
    chk("stale_valid", 32'(insnValid), 32'd0);
    chk("stale_req",   32'(imemReq),   32'd0);
    chk("stale_waddr", pcWrAddr,       32'h0);
    @(negedge clk); #1;
    chk("post_valid", 32'(insnValid),  32'd1);
    chk("post_addr",  insnAddr,        32'h0);
    chk("post_we",    32'(pcWrEnable), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
